// File: rtl/eth_peer_learn_if.sv
// eth_peer_learn_if: GMII receive byte stream into the peer learner and the
// learned-peer outputs back to the ICMP echo/transmit stage.
//   gmii_rx_dv/gmii_rxd : receive data valid and byte (driven by master)
//   pc_ip/pc_mac        : learned peer IPv4 / MAC address (driven by slave)
//   peer_valid          : sticky, set on first learn
//   learn_pulse         : one-cycle strobe per learn
//   learn_src           : 0 = ARP learn, 1 = ICMP learn
//   arp_is_req          : oper of last ARP learn, 1 = request
interface eth_peer_learn_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic [31:0] pc_ip;
    logic [47:0] pc_mac;
    logic        peer_valid;
    logic        learn_pulse;
    logic        learn_src;
    logic        arp_is_req;

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  pc_ip, pc_mac, peer_valid, learn_pulse, learn_src, arp_is_req
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output pc_ip, pc_mac, peer_valid, learn_pulse, learn_src, arp_is_req
    );
endinterface

// File: rtl/eth_peer_learn.sv
// eth_peer_learn: in-line GMII receive parser that learns the host's MAC/IP
// from ARP requests/replies addressed to the board (byte per clock, no buffer).
// Ports:
//   clk   : GMII receive clock
//   rst_n : synchronous, active-low reset
//   bus   : eth_peer_learn_if.slave (GMII rx in, learned peer out)
// Optional feature: define ICMP_LEARN_EN to also learn from ICMP echo
// requests (EtherType 0x0800); otherwise IPv4 frames are dropped and
// learn_src stays 0.
module eth_peer_learn #(
    parameter logic [31:0] BOARD_IP   = 32'hC0A8_010A,
    parameter logic [47:0] BOARD_MAC  = 48'h0011_2233_4455,
    parameter logic [31:0] DEF_PC_IP  = 32'hC0A8_0102,
    parameter logic [47:0] DEF_PC_MAC = 48'hFFFF_FFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    eth_peer_learn_if.slave bus
);
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_ETH_HDR,
        S_ARP_BODY,
        S_IP_BODY,
        S_DROP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dst_bc;
    logic             r_dst_uc;
    logic [47:0]      r_sh_mac;
    logic [31:0]      r_sh_ip;
    logic             r_sh_req;
`ifdef ICMP_LEARN_EN
    logic [47:0]      r_sh_src;
    logic             w_ip_ok;
`endif
    logic [31:0]      r_pc_ip;
    logic [47:0]      r_pc_mac;
    logic             r_peer_valid;
    logic             r_learn_pulse;
    logic             r_learn_src;
    logic             r_arp_is_req;

    logic             w_dv;
    logic [7:0]       w_rxd;
    logic             w_bc_ok;
    logic             w_uc_ok;
    logic             w_arp_ok;

    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
        case (i)
            3'd0:    return m[47:40];
            3'd1:    return m[39:32];
            3'd2:    return m[31:24];
            3'd3:    return m[23:16];
            3'd4:    return m[15:8];
            default: return m[7:0];
        endcase
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] i);
        case (i)
            2'd0:    return a[31:24];
            2'd1:    return a[23:16];
            2'd2:    return a[15:8];
            default: return a[7:0];
        endcase
    endfunction

    assign w_dv  = bus.gmii_rx_dv;
    assign w_rxd = bus.gmii_rxd;

    // Destination MAC: running "still broadcast" / "still ours" flags over bytes 0-5
    always_comb begin
        w_bc_ok = ((r_cnt == '0) || r_dst_bc) && (w_rxd == 8'hFF);
        w_uc_ok = ((r_cnt == '0) || r_dst_uc) && (w_rxd == mac_byte(BOARD_MAC, r_cnt[2:0]));
    end

    // ARP body byte check; offsets not listed are don't-care
    always_comb begin
        w_arp_ok = 1'b1;
        case (r_cnt)
            6'd0, 6'd3, 6'd6:        w_arp_ok = (w_rxd == 8'h00);
            6'd1:                    w_arp_ok = (w_rxd == 8'h01);
            6'd2:                    w_arp_ok = (w_rxd == 8'h08);
            6'd4:                    w_arp_ok = (w_rxd == 8'h06);
            6'd5:                    w_arp_ok = (w_rxd == 8'h04);
            6'd7:                    w_arp_ok = (w_rxd == 8'h01) || (w_rxd == 8'h02);
            6'd24, 6'd25, 6'd26,
            6'd27:                   w_arp_ok = (w_rxd == ip_byte(BOARD_IP, r_cnt[1:0]));
            default:                 w_arp_ok = 1'b1;
        endcase
    end

`ifdef ICMP_LEARN_EN
    // IPv4/ICMP byte check: IHL 5, protocol ICMP, dst = board, echo request
    always_comb begin
        w_ip_ok = 1'b1;
        case (r_cnt)
            6'd0:                    w_ip_ok = (w_rxd == 8'h45);
            6'd9:                    w_ip_ok = (w_rxd == 8'h01);
            6'd16, 6'd17, 6'd18,
            6'd19:                   w_ip_ok = (w_rxd == ip_byte(BOARD_IP, r_cnt[1:0]));
            6'd20:                   w_ip_ok = (w_rxd == 8'h08);
            default:                 w_ip_ok = 1'b1;
        endcase
    end
`endif

    // Parser FSM, shadow capture and commit; r_cnt restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_dst_bc      <= 1'b0;
            r_dst_uc      <= 1'b0;
            r_sh_mac      <= '0;
            r_sh_ip       <= '0;
            r_sh_req      <= 1'b0;
`ifdef ICMP_LEARN_EN
            r_sh_src      <= '0;
`endif
            r_pc_ip       <= DEF_PC_IP;
            r_pc_mac      <= DEF_PC_MAC;
            r_peer_valid  <= 1'b0;
            r_learn_pulse <= 1'b0;
            r_learn_src   <= 1'b0;
            r_arp_is_req  <= 1'b0;
        end else begin
            r_learn_pulse <= 1'b0;
            r_cnt         <= r_cnt + CNT_W'(1);
            if (!w_dv) begin
                // End of frame (or truncation): nothing is committed
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt   <= '0;
                        r_state <= (w_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
                    end
                    S_PREAMBLE: begin
                        if (w_rxd == 8'h55) begin
                            if (r_cnt == 6'd63) r_cnt <= r_cnt;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ((w_rxd == 8'hD5) && (r_cnt >= 6'd6)) ? S_ETH_HDR : S_DROP;
                        end
                    end
                    S_ETH_HDR: begin
                        if (r_cnt < 6'd6) begin
                            r_dst_bc <= w_bc_ok;
                            r_dst_uc <= w_uc_ok;
                            if (!w_bc_ok && !w_uc_ok) begin
                                r_state <= S_DROP;
                                r_cnt   <= '0;
                            end
                        end else if (r_cnt < 6'd12) begin
`ifdef ICMP_LEARN_EN
                            r_sh_src <= {r_sh_src[39:0], w_rxd};
`endif
                        end else if (r_cnt == 6'd12) begin
                            if (w_rxd != 8'h08) begin
                                r_state <= S_DROP;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= '0;
                            if (w_rxd == 8'h06) r_state <= S_ARP_BODY;
`ifdef ICMP_LEARN_EN
                            else if (w_rxd == 8'h00) r_state <= S_IP_BODY;
`endif
                            else r_state <= S_DROP;
                        end
                    end
                    S_ARP_BODY: begin
                        if (!w_arp_ok) begin
                            r_state <= S_DROP;
                            r_cnt   <= '0;
                        end else begin
                            if (r_cnt == 6'd7) r_sh_req <= (w_rxd == 8'h01);
                            if ((r_cnt >= 6'd8) && (r_cnt <= 6'd13)) r_sh_mac <= {r_sh_mac[39:0], w_rxd};
                            if ((r_cnt >= 6'd14) && (r_cnt <= 6'd17)) r_sh_ip <= {r_sh_ip[23:0], w_rxd};
                            if (r_cnt == 6'd27) begin
                                r_pc_mac      <= r_sh_mac;
                                r_pc_ip       <= r_sh_ip;
                                r_arp_is_req  <= r_sh_req;
                                r_learn_src   <= 1'b0;
                                r_peer_valid  <= 1'b1;
                                r_learn_pulse <= 1'b1;
                                r_state       <= S_DROP;
                                r_cnt         <= '0;
                            end
                        end
                    end
`ifdef ICMP_LEARN_EN
                    S_IP_BODY: begin
                        if (!w_ip_ok) begin
                            r_state <= S_DROP;
                            r_cnt   <= '0;
                        end else begin
                            if ((r_cnt >= 6'd12) && (r_cnt <= 6'd15)) r_sh_ip <= {r_sh_ip[23:0], w_rxd};
                            if (r_cnt == 6'd20) begin
                                r_pc_mac      <= r_sh_src;
                                r_pc_ip       <= r_sh_ip;
                                r_learn_src   <= 1'b1;
                                r_peer_valid  <= 1'b1;
                                r_learn_pulse <= 1'b1;
                                r_state       <= S_DROP;
                                r_cnt         <= '0;
                            end
                        end
                    end
`endif
                    S_DROP: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_state <= S_DROP;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.pc_ip       = r_pc_ip;
    assign bus.pc_mac      = r_pc_mac;
    assign bus.peer_valid  = r_peer_valid;
    assign bus.learn_pulse = r_learn_pulse;
    assign bus.learn_src   = r_learn_src;
    assign bus.arp_is_req  = r_arp_is_req;
endmodule

// File: tb/tb_eth_peer_learn.sv
// tb_eth_peer_learn: table-driven, hand-sequenced and randomized frames for
// eth_peer_learn, checked against a field-level frame model.
`timescale 1ns/1ps
module tb_eth_peer_learn;
    localparam logic [31:0] BOARD_IP   = 32'hC0A8_010A;
    localparam logic [47:0] BOARD_MAC  = 48'h0011_2233_4455;
    localparam logic [31:0] DEF_PC_IP  = 32'hC0A8_0102;
    localparam logic [47:0] DEF_PC_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] BC_MAC     = 48'hFFFF_FFFF_FFFF;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        string       name;
        bit          icmp;
        int          pre_len;
        logic [47:0] dst;
        logic [15:0] oper;
        logic [47:0] snd_mac;
        logic [31:0] snd_ip;
        logic [31:0] tgt_ip;
        int          bad_off;
        int          exp_pulses;
        logic [31:0] exp_ip;
        logic [47:0] exp_mac;
        bit          exp_valid;
        bit          exp_req;
        bit          exp_src;
    } vec_t;

    typedef struct packed {
        logic        learn;
        logic [47:0] mac;
        logic [31:0] ip;
        logic        req;
        logic        src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #4 clk = ~clk;

    eth_peer_learn_if bus();

    eth_peer_learn #(
        .BOARD_IP   (BOARD_IP),
        .BOARD_MAC  (BOARD_MAC),
        .DEF_PC_IP  (DEF_PC_IP),
        .DEF_PC_MAC (DEF_PC_MAC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses;
    int          last_pulse_idx;
    logic [31:0] exp_ip;
    logic [47:0] exp_mac;
    bit          exp_valid;
    bit          exp_req;
    bit          exp_src;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc_ip"},       64'(bus.pc_ip),       64'(exp_ip));
        check({tag, ".pc_mac"},      64'(bus.pc_mac),      64'(exp_mac));
        check({tag, ".peer_valid"},  64'(bus.peer_valid),  64'(exp_valid));
        check({tag, ".arp_is_req"},  64'(bus.arp_is_req),  64'(exp_req));
        check({tag, ".learn_src"},   64'(bus.learn_src),   64'(exp_src));
    endtask

    // Drive one byte per clock with dv high, then dv low for gap cycles; count pulses
    task automatic drive(input byte_q_t q, input int gap);
        foreach (q[i]) begin
            bus.gmii_rx_dv = 1'b1;
            bus.gmii_rxd   = q[i];
            @(posedge clk);
            #1;
            if (bus.learn_pulse === 1'b1) begin
                pulses++;
                last_pulse_idx = i;
            end
        end
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rxd   = 8'h00;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (bus.learn_pulse === 1'b1) begin
                pulses++;
                last_pulse_idx = -1;
            end
        end
    endtask

    function automatic byte_q_t build(input bit icmp, input int pre_len, input logic [47:0] dst,
                                      input logic [15:0] oper, input logic [47:0] smac,
                                      input logic [31:0] sip, input logic [31:0] tip, input int bad_off);
        byte_q_t     q;
        logic [7:0]  body [28];
        logic [47:0] eth_src;
        for (int i = 0; i < pre_len; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) q.push_back(dst[8*i +: 8]);
        // ARP frames carry an Ethernet source unlike the ARP sender
        eth_src = icmp ? smac : 48'h0200_0000_00E1;
        for (int i = 5; i >= 0; i--) q.push_back(eth_src[8*i +: 8]);
        q.push_back(8'h08);
        q.push_back(icmp ? 8'h00 : 8'h06);
        body = '{default: 8'h00};
        if (!icmp) begin
            body[1] = 8'h01; body[2] = 8'h08; body[4] = 8'h06; body[5] = 8'h04;
            body[6] = oper[15:8]; body[7] = oper[7:0];
            for (int k = 0; k < 6; k++) body[8+k]  = smac[8*(5-k) +: 8];
            for (int k = 0; k < 4; k++) body[14+k] = sip[8*(3-k) +: 8];
            for (int k = 0; k < 6; k++) body[18+k] = 8'($urandom);
            for (int k = 0; k < 4; k++) body[24+k] = tip[8*(3-k) +: 8];
        end else begin
            body[0] = 8'h45; body[3] = 8'h3C; body[8] = 8'h40; body[9] = 8'h01;
            body[10] = 8'($urandom); body[11] = 8'($urandom);
            for (int k = 0; k < 4; k++) body[12+k] = sip[8*(3-k) +: 8];
            for (int k = 0; k < 4; k++) body[16+k] = tip[8*(3-k) +: 8];
            body[20] = 8'h08;
            for (int k = 22; k < 28; k++) body[k] = 8'($urandom);
        end
        if (bad_off >= 0 && bad_off < 28) body[bad_off] = body[bad_off] ^ 8'h01;
        for (int k = 0; k < 28; k++) q.push_back(body[k]);
        for (int k = 0; k < 22; k++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic logic [47:0] get_be(input byte_q_t q, input int at, input int n);
        logic [47:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v = {v[39:0], q[at+k]};
        return v;
    endfunction

    function automatic byte_q_t sub(input byte_q_t q, input int a, input int n);
        byte_q_t r;
        for (int i = a; i < a + n && i < q.size(); i++) r.push_back(q[i]);
        return r;
    endfunction

    // Field-level frame model: decides learn and the learned values from the bytes seen with dv high
    function automatic exp_t model(input byte_q_t q);
        exp_t        e;
        int          p;
        int          h;
        int          b;
        bit          bc;
        bit          uc;
        logic [47:0] bm;
        logic [15:0] et;
        logic [15:0] oper;
        e  = '0;
        bm = BOARD_MAC;
        p  = 0;
        while (p < q.size() && q[p] == 8'h55) p++;
        if (p < 7 || p >= q.size() || q[p] != 8'hD5) return e;
        h = p + 1;
        b = h + 14;
        if (q.size() < b) return e;
        bc = 1'b1;
        uc = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bc = bc && (q[h+k] == 8'hFF);
            uc = uc && (q[h+k] == bm[8*(5-k) +: 8]);
        end
        if (!(bc || uc)) return e;
        et = {q[h+12], q[h+13]};
        if (et == 16'h0806 && q.size() >= b + 28) begin
            oper = 16'(get_be(q, b + 6, 2));
            if (16'(get_be(q, b, 2)) == 16'h0001 && 16'(get_be(q, b + 2, 2)) == 16'h0800 &&
                q[b+4] == 8'h06 && q[b+5] == 8'h04 && (oper == 16'h0001 || oper == 16'h0002) &&
                32'(get_be(q, b + 24, 4)) == BOARD_IP) begin
                e.learn = 1'b1;
                e.mac   = get_be(q, b + 8, 6);
                e.ip    = 32'(get_be(q, b + 14, 4));
                e.req   = (oper == 16'h0001);
                e.src   = 1'b0;
            end
        end
`ifdef ICMP_LEARN_EN
        else if (et == 16'h0800 && q.size() >= b + 21) begin
            if (q[b] == 8'h45 && q[b+9] == 8'h01 && 32'(get_be(q, b + 16, 4)) == BOARD_IP &&
                q[b+20] == 8'h08) begin
                e.learn = 1'b1;
                e.mac   = get_be(q, h + 6, 6);
                e.ip    = 32'(get_be(q, b + 12, 4));
                e.src   = 1'b1;
            end
        end
`endif
        return e;
    endfunction

    task automatic apply_model(input exp_t e);
        if (e.learn) begin
            exp_ip    = e.ip;
            exp_mac   = e.mac;
            exp_valid = 1'b1;
            exp_src   = e.src;
            if (!e.src) exp_req = e.req;
        end
    endtask

    vec_t vecs [9];

    initial begin
        byte_q_t     q;
        exp_t        e;
        int          gap;
        int          sel;
        bit          icmp;
        int          pre;
        logic [47:0] dst;
        logic [15:0] oper;
        logic [31:0] tip;
        int          bad;
        int          cut;

        vecs[0] = '{"tgt_ip_miss", 1'b0, 7, BC_MAC, 16'h0001, 48'h02AA_BBCC_DDEE, 32'hC0A8_0102, 32'hC0A8_010B, -1,
                    0, DEF_PC_IP, DEF_PC_MAC, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"short_preamble", 1'b0, 5, BC_MAC, 16'h0001, 48'h02AA_BBCC_DDEE, 32'hC0A8_0102, BOARD_IP, -1,
                    0, DEF_PC_IP, DEF_PC_MAC, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"mcast_dst", 1'b0, 7, 48'h0100_5E00_0001, 16'h0001, 48'h02AA_BBCC_DDEE, 32'hC0A8_0102, BOARD_IP, -1,
                    0, DEF_PC_IP, DEF_PC_MAC, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{"arp_req_bc", 1'b0, 7, BC_MAC, 16'h0001, 48'h02AA_BBCC_DDEE, 32'hC0A8_0102, BOARD_IP, -1,
                    1, 32'hC0A8_0102, 48'h02AA_BBCC_DDEE, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{"arp_rep_uc", 1'b0, 7, BOARD_MAC, 16'h0002, 48'h0211_2233_4466, 32'hC0A8_0132, BOARD_IP, -1,
                    1, 32'hC0A8_0132, 48'h0211_2233_4466, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"bad_hlen", 1'b0, 7, BC_MAC, 16'h0001, 48'h02DE_ADBE_EF00, 32'hC0A8_0144, BOARD_IP, 4,
                    0, 32'hC0A8_0132, 48'h0211_2233_4466, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{"bad_oper", 1'b0, 7, BC_MAC, 16'h0003, 48'h02DE_ADBE_EF00, 32'hC0A8_0144, BOARD_IP, -1,
                    0, 32'hC0A8_0132, 48'h0211_2233_4466, 1'b1, 1'b0, 1'b0};
`ifdef ICMP_LEARN_EN
        vecs[7] = '{"icmp_echo", 1'b1, 7, BOARD_MAC, 16'h0000, 48'h0200_0000_0007, 32'h0A00_0007, BOARD_IP, -1,
                    1, 32'h0A00_0007, 48'h0200_0000_0007, 1'b1, 1'b0, 1'b1};
`else
        vecs[7] = '{"icmp_echo", 1'b1, 7, BOARD_MAC, 16'h0000, 48'h0200_0000_0007, 32'h0A00_0007, BOARD_IP, -1,
                    0, 32'hC0A8_0132, 48'h0211_2233_4466, 1'b1, 1'b0, 1'b0};
`endif
        vecs[8] = '{"arp_req_long_pre", 1'b0, 9, BC_MAC, 16'h0001, 48'h02DE_ADBE_EF01, 32'hC0A8_0163, BOARD_IP, -1,
                    1, 32'hC0A8_0163, 48'h02DE_ADBE_EF01, 1'b1, 1'b1, 1'b0};

        // Reset state
        rst_n          = 1'b0;
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rxd   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        exp_ip = DEF_PC_IP; exp_mac = DEF_PC_MAC; exp_valid = 1'b0; exp_req = 1'b0; exp_src = 1'b0;
        check_outputs("reset");
        check("reset.learn_pulse", 64'(bus.learn_pulse), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int v = 0; v < 9; v++) begin
            q = build(vecs[v].icmp, vecs[v].pre_len, vecs[v].dst, vecs[v].oper, vecs[v].snd_mac,
                      vecs[v].snd_ip, vecs[v].tgt_ip, vecs[v].bad_off);
            pulses = 0;
            last_pulse_idx = -2;
            drive(q, 2);
            exp_ip = vecs[v].exp_ip; exp_mac = vecs[v].exp_mac; exp_valid = vecs[v].exp_valid;
            exp_req = vecs[v].exp_req; exp_src = vecs[v].exp_src;
            check({vecs[v].name, ".pulses"}, 64'(pulses), 64'(vecs[v].exp_pulses));
            check_outputs(vecs[v].name);
            if (vecs[v].exp_pulses == 1)
                check({vecs[v].name, ".pulse_at"}, 64'(last_pulse_idx),
                      64'(vecs[v].pre_len + 1 + 14 + (vecs[v].icmp ? 20 : 27)));
        end

        // Truncated frame (dv drops at ARP body byte 20), 1-cycle gap, then a valid frame
        q = build(1'b0, 7, BC_MAC, 16'h0001, 48'h02AB_CDEF_0123, 32'hC0A8_0177, BOARD_IP, -1);
        pulses = 0;
        drive(sub(q, 0, 8 + 14 + 20), 1);
        check("trunc.pulses", 64'(pulses), 64'd0);
        check_outputs("trunc");
        q = build(1'b0, 7, BOARD_MAC, 16'h0002, 48'h0210_2030_4050, 32'hC0A8_0178, BOARD_IP, -1);
        pulses = 0;
        drive(q, 2);
        exp_ip = 32'hC0A8_0178; exp_mac = 48'h0210_2030_4050; exp_valid = 1'b1; exp_req = 1'b0; exp_src = 1'b0;
        check("after_gap.pulses", 64'(pulses), 64'd1);
        check_outputs("after_gap");

        // Reset mid-frame: defaults return, remainder of the frame is ignored
        q = build(1'b0, 7, BC_MAC, 16'h0001, 48'h0266_7788_99AA, 32'hC0A8_0199, BOARD_IP, -1);
        pulses = 0;
        drive(sub(q, 0, 30), 0);
        rst_n = 1'b0;
        drive(sub(q, 30, 2), 0);
        rst_n = 1'b1;
        exp_ip = DEF_PC_IP; exp_mac = DEF_PC_MAC; exp_valid = 1'b0; exp_req = 1'b0; exp_src = 1'b0;
        check_outputs("mid_reset");
        drive(sub(q, 32, q.size() - 32), 2);
        check("mid_reset.pulses", 64'(pulses), 64'd0);
        check_outputs("mid_reset_tail");

        // Randomized frames against the model
        for (int r = 0; r < 40; r++) begin
            icmp = ($urandom_range(0, 3) == 0);
            pre  = int'($urandom_range(5, 9));
            sel  = int'($urandom_range(0, 5));
            dst  = (sel < 3) ? BC_MAC : (sel < 5) ? BOARD_MAC : {16'($urandom), $urandom};
            sel  = int'($urandom_range(0, 7));
            oper = (sel == 0) ? 16'h0003 : (sel < 4) ? 16'h0001 : 16'h0002;
            tip  = ($urandom_range(0, 5) == 0) ? BOARD_IP + 32'd1 : BOARD_IP;
            bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 27)) : -1;
            q    = build(icmp, pre, dst, oper, {16'($urandom), $urandom}, $urandom, tip, bad);
            if ($urandom_range(0, 4) == 0) begin
                cut = int'($urandom_range(1, 60));
                while (q.size() > cut) void'(q.pop_back());
            end
            e   = model(q);
            gap = int'($urandom_range(1, 3));
            pulses = 0;
            drive(q, gap);
            apply_model(e);
            check($sformatf("rand%0d.pulses", r), 64'(pulses), 64'(e.learn));
            check_outputs($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_peer_learn.md
Name: eth_peer_learn

Overview:
- Receive-side GMII frame parser in the gmii_eth_rxc domain.
- Watches incoming Ethernet frames for ARP requests and replies addressed to the board, and captures the sender's MAC and IP.
- Drives the pc_mac/pc_ip inputs of the ICMP echo/transmit stage, so replies target the real host instead of hard-coded addresses.
- Parsing is in-line, byte per clock; no buffering.

Parameters:
- BOARD_IP, 32'hC0A8_010A: board IPv4 address (192.168.1.10); ARP target IP must match.
- BOARD_MAC, 48'h0011_2233_4455: board MAC; accepted unicast destination.
- DEF_PC_IP, 32'hC0A8_0102: pc_ip value after reset.
- DEF_PC_MAC, 48'hFFFF_FFFF_FFFF: pc_mac value after reset.

Ports:
- clk  in  1  GMII receive clock (125 MHz).
- rst_n  in  1  reset; synchronous, active-low.
- gmii_rx_dv  in  1  GMII receive data valid (rxctl).
- gmii_rxd  in  8  GMII receive byte.
- pc_ip  out  32  learned peer IPv4 address.
- pc_mac  out  48  learned peer MAC.
- peer_valid  out  1  sticky; set on first successful learn.
- learn_pulse  out  1  one-cycle strobe on every successful learn.
- learn_src  out  1  source of last learn: 0 = ARP, 1 = ICMP.
- arp_is_req  out  1  ARP oper of last ARP learn: 1 = request (0x0001), 0 = reply (0x0002).

Behaviour:
- Reset values: pc_ip = DEF_PC_IP, pc_mac = DEF_PC_MAC, peer_valid = 0, learn_pulse = 0, learn_src = 0, arp_is_req = 0. The FSM returns to IDLE and clears its byte counter.
- States:
  - IDLE
  - PREAMBLE
  - ETH_HDR: 14 bytes
  - ARP_BODY: 28 bytes
  - IP_BODY: macro only
  - DROP
- A 6-bit byte counter runs within each header state and resets on every state change.
- IDLE -> PREAMBLE when gmii_rx_dv = 1 and gmii_rxd = 0x55.
- PREAMBLE:
  - 0x55 increments the count.
  - 0xD5 with count >= 6 (7 preamble bytes seen) -> ETH_HDR.
  - 0xD5 with fewer, or any other byte -> DROP.
- ETH_HDR:
  - Bytes 0-5 (destination MAC) must all be 0xFF or all equal BOARD_MAC (MSB first); otherwise DROP.
  - Bytes 6-11 (source MAC) are stored in a shadow register.
  - Bytes 12-13 = 0x0806 -> ARP_BODY; any other EtherType -> DROP.
- ARP_BODY, byte offsets within the body:
  - 0-1: htype, must be 0x0001.
  - 2-3: ptype, must be 0x0800.
  - 4: hlen, must be 6.
  - 5: plen, must be 4.
  - 6-7: oper, must be 0x0001 or 0x0002; latched in shadow.
  - 8-13: sender MAC, to shadow.
  - 14-17: sender IP, to shadow.
  - 18-23: target MAC, ignored.
  - 24-27: target IP, must equal BOARD_IP.
  - Any mismatch -> DROP immediately.
- Commit:
  - Occurs on the edge after byte 27 is sampled and matches. pc_mac <= ARP sender MAC (not the Ethernet source), pc_ip <= sender IP, arp_is_req <= (oper == 1), learn_src <= 0, peer_valid <= 1, learn_pulse = 1 for exactly 1 cycle.
  - FSM then -> DROP to discard the padding and FCS.
  - FCS is not checked.
- DROP waits for gmii_rx_dv = 0, then -> IDLE.
- gmii_rx_dv = 0 in any non-IDLE state -> IDLE immediately, no commit. Shadow registers never reach the outputs on a truncated frame.
- pc_ip/pc_mac change only on commit; they are stable otherwise, including through dropped or malformed frames.
- Back-to-back frames: the FSM re-arms in IDLE one cycle after gmii_rx_dv falls. A 1-cycle inter-frame gap must be accepted.
- Reset mid-frame: the outputs return to defaults and the remainder of the frame is ignored. Bytes with dv = 1 that do not start with 0x55 after reset go to DROP.

Optional Feature:
ICMP_LEARN_EN
- Defined:
  - EtherType 0x0800 in ETH_HDR -> IP_BODY.
  - Required IP header values: byte 0 = 0x45 (IHL ≠ 5 -> DROP), byte 9 (protocol) = 0x01, bytes 16-19 (destination IP) = BOARD_IP.
  - Bytes 12-15 (source IP) go to shadow.
  - Byte 20, the ICMP type, must be 0x08.
  - Commit on the edge after byte 20: pc_mac <= Ethernet source MAC, pc_ip <= IP source, learn_src <= 1, arp_is_req unchanged, peer_valid and learn_pulse as for ARP.
- Undefined: EtherType 0x0800 -> DROP; learn_src is constant 0.

Test Plan:
- Broadcast ARP request, sender 02:AA:BB:CC:DD:EE / 192.168.1.2, target 192.168.1.10 -> one learn_pulse after target byte 27; pc_mac = 48'h02AABBCCDDEE, pc_ip = 32'hC0A80102, arp_is_req = 1, peer_valid = 1.
- Same frame with target IP 192.168.1.11 -> no pulse; outputs stay at reset defaults; peer_valid = 0.
- Unicast ARP reply to BOARD_MAC from 192.168.1.50 -> pc_ip = 32'hC0A80132, arp_is_req = 0.
- Valid ARP request with gmii_rx_dv dropped at body byte 20, then a full valid frame after a 1-cycle gap -> no update from the first frame; the second frame commits normally.
- Frame with only 5 preamble bytes before 0xD5, or destination MAC 01:00:5E:00:00:01 -> dropped, no learn_pulse.
- With ICMP_LEARN_EN: echo request from 10.0.0.7 / MAC 02:00:00:00:00:07 to BOARD_IP -> learn_pulse after IP byte 20, learn_src = 1, pc_ip = 32'h0A000007. Without the macro, the same frame produces no pulse.
